relu_maxpool_2x2: RTL and testbench

- Streaming pooling stage directly downstream of the convolution block; consumes its raster-ordered 16-bit feature-map pixels.
- Performs 2x2, stride-2 max pooling on the stream and produces one pooled pixel per 2x2 window.
- Uses a half-width line buffer, so no full frame is ever stored.
- Output feeds the next CNN layer or a readout.

---
 rtl/relu_maxpool_2x2.sv | 105 ++++++++++
 tb/tb_relu_maxpool_2x2.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_2x2.sv
// rtl/relu_maxpool_2x2.sv - streaming 2x2 stride-2 signed max pool with half-width line buffer
// Optional output ReLU enabled by defining RELU_MAXPOOL_RELU_EN.
module relu_maxpool_2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_done
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic {
    EVEN_ROW = 1'b0,
    ODD_ROW  = 1'b1
  } row_state_t;

  row_state_t        r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_pair;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_frame_done;

  // Holds the horizontal max of each pair from the even row until the odd row consumes it.
  logic [DATA_W-1:0] r_linebuf [HALF_W];

  logic              w_col_last;
  logic              w_row_last;
  logic              w_odd_col;
  logic [LB_AW-1:0]  w_lb_idx;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_lb_rd;
  logic [DATA_W-1:0] w_vmax;
  logic [DATA_W-1:0] w_pool_out;

  assign w_col_last = (r_col == COL_W'(IMG_W - 1));
  assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
  assign w_odd_col  = r_col[0];
  assign w_lb_idx   = LB_AW'(r_col >> 1);

  assign w_hmax  = ($signed(r_pair) > $signed(in_data)) ? r_pair : in_data;
  assign w_lb_rd = r_linebuf[w_lb_idx];
  assign w_vmax  = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;

`ifdef RELU_MAXPOOL_RELU_EN
  assign w_pool_out = w_vmax[DATA_W-1] ? '0 : w_vmax;
`else
  assign w_pool_out = w_vmax;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= EVEN_ROW;
      r_col        <= '0;
      r_row        <= '0;
      r_pair       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (w_col_last) begin
          r_col   <= '0;
          r_row   <= w_row_last ? '0 : r_row + 1'b1;
          r_state <= (r_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end else begin
          r_col <= r_col + 1'b1;
        end

        if (!w_odd_col) begin
          r_pair <= in_data;
        end else if (r_state == ODD_ROW) begin
          r_out_data   <= w_pool_out;
          r_out_valid  <= 1'b1;
          r_frame_done <= w_row_last && w_col_last;
        end
      end
    end
  end

  // Contents are never reset: each entry is written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_valid && w_odd_col && (r_state == EVEN_ROW)) begin
      r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// tb/tb_relu_maxpool_2x2.sv - directed self-checking bench for relu_maxpool_2x2 on a 4x4 map
module tb_relu_maxpool_2x2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        frame_done;

  int          errors;
  int          checks;
  logic [15:0] e_last;
  logic [15:0] frame_pix [16];
  logic [15:0] frame_exp [4];

  relu_maxpool_2x2 #(
    .DATA_W(16),
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_outputs(input logic ev, input logic [15:0] ed, input logic efd, input string tag);
    if (ev) e_last = ed;
    checks++;
    assert (out_valid === ev) else begin
      errors++;
      $error("FAIL %s out_valid got=%b exp=%b", tag, out_valid, ev);
    end
    checks++;
    assert (out_data === e_last) else begin
      errors++;
      $error("FAIL %s out_data got=%h exp=%h", tag, out_data, e_last);
    end
    checks++;
    assert (frame_done === efd) else begin
      errors++;
      $error("FAIL %s frame_done got=%b exp=%b", tag, frame_done, efd);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic ev, input logic [15:0] ed,
                      input logic efd, input string tag);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    check_outputs(ev, ed, efd, tag);
  endtask

  task automatic run_frame(input int gap_max, input string tag);
    int  n;
    int  k;
    logic is_out;
    for (int i = 0; i < 16; i++) begin
      if (gap_max > 0 && $urandom_range(0, 1) == 1) begin
        n = $urandom_range(1, gap_max);
        for (int g = 0; g < n; g++) step(1'b0, 16'hDEAD, 1'b0, 16'h0, 1'b0, {tag, "_gap"});
      end
      is_out = (i == 5) || (i == 7) || (i == 13) || (i == 15);
      k      = (i >> 3) * 2 + ((i >> 1) & 1);
      step(1'b1, frame_pix[i], is_out, is_out ? frame_exp[k] : 16'h0, i == 15, tag);
    end
  endtask

  task automatic load_ramp(input logic [15:0] base);
    for (int i = 0; i < 16; i++) frame_pix[i] = base + 16'(i);
    frame_exp[0] = base + 16'd5;
    frame_exp[1] = base + 16'd7;
    frame_exp[2] = base + 16'd13;
    frame_exp[3] = base + 16'd15;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    e_last = 16'h0;
    check_outputs(1'b0, 16'h0, 1'b0, tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    e_last   = 16'h0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;

    do_reset("reset");
    step(1'b0, 16'h1234, 1'b0, 16'h0, 1'b0, "idle_after_reset");

    load_ramp(16'd0);
    run_frame(0, "ramp");

    // Descending ramp: each window max is its top-left pixel, exercising the line buffer side.
    for (int i = 0; i < 16; i++) frame_pix[i] = 16'(15 - i);
    frame_exp[0] = 16'd15;
    frame_exp[1] = 16'd13;
    frame_exp[2] = 16'd7;
    frame_exp[3] = 16'd5;
    run_frame(0, "desc");

    for (int i = 0; i < 16; i++) frame_pix[i] = 16'hFFFD;
`ifdef RELU_MAXPOOL_RELU_EN
    for (int k = 0; k < 4; k++) frame_exp[k] = 16'h0000;
`else
    for (int k = 0; k < 4; k++) frame_exp[k] = 16'hFFFD;
`endif
    run_frame(0, "neg3");

    frame_pix = '{16'h7FFF, 16'h8000, 16'h8000, 16'hFFFF,
                  16'h8000, 16'h8000, 16'h8000, 16'h8000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
    frame_exp[0] = 16'h7FFF;
`ifdef RELU_MAXPOOL_RELU_EN
    frame_exp[1] = 16'h0000;
`else
    frame_exp[1] = 16'hFFFF;
`endif
    frame_exp[2] = 16'h0000;
    frame_exp[3] = 16'h0000;
    run_frame(0, "signed");

    load_ramp(16'd0);
    run_frame(3, "gaps");

    for (int i = 0; i < 6; i++) begin
      step(1'b1, 16'(i), i == 5, 16'd5, 1'b0, "partial");
    end
    do_reset("reset_mid");
    load_ramp(16'd0);
    run_frame(0, "after_reset");

    load_ramp(16'd0);
    run_frame(0, "b2b_a");
    load_ramp(16'd100);
    run_frame(0, "b2b_b");

    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "tail_idle");
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, "tail_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
